// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types and constants for the debug trace buffer
package dbg_pkg;

  localparam int DROP_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DONE  = 3'd3,
    DUMP  = 3'd4
  } trace_state_e;

  // Entry layout at the default configuration (4 channels, 16-bit ts, 32-bit payload);
  // the buffer builds the same {ch_id, ts, data} layout from its own parameters.
  typedef struct packed {
    logic [1:0]  ch_id;
    logic [15:0] ts;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/dbg_trace_buffer_if.sv
// rtl/dbg_trace_buffer_if.sv - readout stream between the trace buffer and its consumer
interface dbg_trace_buffer_if #(
  parameter int CH_W   = 2,
  parameter int TS_W   = 16,
  parameter int DATA_W = 32
);
  logic              rd_valid;
  logic              rd_ready;
  logic [CH_W-1:0]   rd_ch;
  logic [TS_W-1:0]   rd_ts;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (output rd_valid, rd_ch, rd_ts, rd_data, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_ch, rd_ts, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/dbg_rr_arbiter.sv
// rtl/dbg_rr_arbiter.sv - round-robin pick of the lowest requester at or after rr_ptr
module dbg_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any_gnt
);
  int c;

  // Scan channels starting at rr_ptr; the first requester wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    c       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (int'(rr_ptr) + i) % NUM_CH;
      if (!any_gnt && ((req >> c) & NUM_CH'(1)) != '0) begin
        any_gnt = 1'b1;
        gnt_idx = CH_W'(c);
        gnt     = NUM_CH'(1) << c;
      end
    end
  end
endmodule

// File: rtl/dbg_trace_buffer.sv
// rtl/dbg_trace_buffer.sv - armed/triggered circular trace capture with oldest-first readout
module dbg_trace_buffer
  import dbg_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  parameter  int TS_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int PC_W   = AW + 1,
  localparam int DRW    = CH_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0][DATA_W-1:0] ch_data,
  input  logic                         arm,
  input  logic                         trig_in,
  input  logic [PC_W-1:0]              post_cnt,
  input  logic                         dump_start,
  dbg_trace_buffer_if.master           rd,
  output trace_state_e                 state_o,
  output logic [DROP_W-1:0]            drop_cnt
);
  typedef struct packed {
    logic [CH_W-1:0]   ch_id;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t wr_entry, rd_entry;

  trace_state_e     state_q, state_d;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_addr;
  logic [PC_W-1:0]  fill, rem, rem_eff;
  logic [PC_W-1:0]  post_q, post_wr, post_wr_d;
  logic [TS_W-1:0]  ts;
  logic [CH_W-1:0]  rr_ptr, gnt_idx;
  logic [NUM_CH-1:0] gnt;
  logic             any_gnt;
  logic [DRW-1:0]   drops;
  logic [DROP_W:0]  drop_sum;
  logic             capture, trig_hit, we, arm_take, dump_go, hs, load;
  logic             rd_valid_q, rd_last_q;

  dbg_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req     (ch_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Control decode, post-window accounting and next-state selection
  always_comb begin
    capture  = (state_q == ARMED) || (state_q == POST);
    trig_hit = (state_q == ARMED) && trig_in;
    // A zero-length post window stops on the trigger itself, so that event is not kept
    we       = capture && any_gnt && !(trig_hit && post_q == '0);
    dump_go  = (state_q == DONE) && dump_start;
    arm_take = arm && ((state_q == IDLE) || ((state_q == DONE) && !dump_start));
    hs       = rd_valid_q && rd.rd_ready;
    rem_eff  = (state_q == DONE) ? fill : rem;
    rd_addr  = (state_q == DONE) ? (wr_ptr - fill[AW-1:0]) : rd_ptr;
    load     = (dump_go || ((state_q == DUMP) && (!rd_valid_q || hs))) && (rem_eff != '0);

    drops = '0;
    for (int i = 0; i < NUM_CH; i++) drops = drops + DRW'(ch_valid[i] & ~gnt[i]);
    drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(drops);

    if (trig_hit)              post_wr_d = PC_W'(we);
    else if (state_q == POST)  post_wr_d = post_wr + PC_W'(we);
    else                       post_wr_d = post_wr;

    wr_entry.ch_id = gnt_idx;
    wr_entry.ts    = ts;
    wr_entry.data  = ch_data[gnt_idx];

    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED:   if (trig_in) state_d = (post_wr_d == post_q) ? DONE : POST;
      POST:    if (post_wr_d == post_q) state_d = DONE;
      DONE:    if (dump_start) state_d = DUMP;
               else if (arm) state_d = ARMED;
      DUMP:    if ((hs && rd_last_q) || (!rd_valid_q && rem == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM register plus write pointer, fill level, timestamp, arbitration and drop counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      ts       <= '0;
      rr_ptr   <= '0;
      post_q   <= '0;
      post_wr  <= '0;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (arm_take) begin
        wr_ptr  <= '0;
        fill    <= '0;
        ts      <= '0;
        rr_ptr  <= '0;
        post_wr <= '0;
        post_q  <= (post_cnt > PC_W'(DEPTH)) ? PC_W'(DEPTH) : post_cnt;
      end else if (capture) begin
        ts       <= ts + 1'b1;
        post_wr  <= post_wr_d;
        drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        if (we) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill != PC_W'(DEPTH)) fill <= fill + 1'b1;
          rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  // Trace RAM write port; the array itself carries no reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_entry;
  end

  // Registered readout: fetch the next entry whenever the output slot is empty or being taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      rem        <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_entry   <= '0;
    end else if (load) begin
      rd_entry   <= mem[rd_addr];
      rd_valid_q <= 1'b1;
      rd_last_q  <= (rem_eff == PC_W'(1));
      rd_ptr     <= rd_addr + 1'b1;
      rem        <= rem_eff - 1'b1;
    end else begin
      if (hs) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
      if (dump_go) rem <= '0;
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign rd.rd_ch    = rd_entry.ch_id;
  assign rd.rd_ts    = rd_entry.ts;
  assign rd.rd_data  = rd_entry.data;
  assign state_o     = state_q;
endmodule

// File: tb/tb_dbg_trace_buffer.sv
// tb/tb_dbg_trace_buffer.sv - randomized directed bench for dbg_trace_buffer against a queue model
module tb_dbg_trace_buffer;
  import dbg_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int TS_W   = 16;
  localparam int CH_W   = 2;
  localparam int PC_W   = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]             ch_valid = '0;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_data = '0;
  logic                          arm = 1'b0;
  logic                          trig_in = 1'b0;
  logic [PC_W-1:0]               post_cnt = '0;
  logic                          dump_start = 1'b0;
  trace_state_e                  state_o;
  logic [15:0]                   drop_cnt;

  dbg_trace_buffer_if #(.CH_W(CH_W), .TS_W(TS_W), .DATA_W(DATA_W)) rd_if ();

  dbg_trace_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .arm        (arm),
    .trig_in    (trig_in),
    .post_cnt   (post_cnt),
    .dump_start (dump_start),
    .rd         (rd_if),
    .state_o    (state_o),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    int                ch;
    int                ts;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: every accepted write in order, plus capture bookkeeping
  ent_t hist[$];
  int   m_rr, m_ts, m_post, m_postw, m_drops;
  bit   m_trig, m_done;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int pc);
    arm = 1'b1;
    post_cnt = PC_W'(pc);
    ch_valid = '0;
    tick();
    arm = 1'b0;
    hist.delete();
    m_ts = 0; m_rr = 0; m_postw = 0; m_trig = 0; m_done = 0;
    m_post = (pc > DEPTH) ? DEPTH : pc;
    chk("arm_state", state_o, ARMED);
  endtask

  // One capture cycle: present events/trigger, advance the model, then compare
  task automatic cap_cycle(input logic [NUM_CH-1:0] v, input bit trig);
    int g, c;
    ent_t e;
    ch_valid = v;
    trig_in  = trig;
    for (int k = 0; k < NUM_CH; k++) ch_data[k] = $urandom;
    if (!m_done) begin
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && v[CH_W'(c)]) g = c;
      end
      if (trig && !m_trig && m_post == 0) begin
        m_trig = 1;
        m_done = 1;
      end else begin
        if (g >= 0) begin
          m_drops = m_drops + $countones(v) - 1;
          if (m_drops > 65535) m_drops = 65535;
          e.ch = g; e.ts = m_ts % 65536; e.data = ch_data[CH_W'(g)];
          hist.push_back(e);
          m_rr = (g + 1) % NUM_CH;
        end
        if (trig) m_trig = 1;
        if (m_trig && g >= 0) m_postw++;
        if (m_trig && m_postw == m_post) m_done = 1;
      end
      m_ts++;
    end
    tick();
    ch_valid = '0;
    trig_in  = 1'b0;
    chk("cap_state", state_o, m_done ? DONE : (m_trig ? POST : ARMED));
    chk("drop_cnt", drop_cnt, 64'(m_drops));
  endtask

  // Readout: mode 0 always ready, 1 ready toggling 1010.., 2 random ready
  task automatic do_dump(input int mode);
    ent_t exp_q[$];
    int   n;
    bit   ph, r;
    n = (hist.size() > DEPTH) ? DEPTH : hist.size();
    for (int i = hist.size() - n; i < hist.size(); i++) exp_q.push_back(hist[i]);
    rd_if.rd_ready = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    ph = 1;
    for (int cyc = 0; cyc < 4 * DEPTH + 8 && !(exp_q.size() == 0 && state_o == IDLE); cyc++) begin
      if (exp_q.size() > 0) begin
        chk("rd_valid", rd_if.rd_valid, 1);
        chk("rd_ch", rd_if.rd_ch, 64'(exp_q[0].ch));
        chk("rd_ts", rd_if.rd_ts, 64'(exp_q[0].ts));
        chk("rd_data", rd_if.rd_data, exp_q[0].data);
        chk("rd_last", rd_if.rd_last, exp_q.size() == 1);
      end else begin
        chk("rd_valid_empty", rd_if.rd_valid, 0);
      end
      case (mode)
        0:       r = 1;
        1:       r = ph;
        default: r = 1'($urandom_range(0, 1));
      endcase
      ph = !ph;
      rd_if.rd_ready = r;
      if (r && rd_if.rd_valid === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
      tick();
    end
    rd_if.rd_ready = 1'b0;
    chk("dump_drained", 64'(exp_q.size()), 0);
    chk("dump_idle", state_o, IDLE);
    chk("dump_valid_off", rd_if.rd_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_if.rd_ready = 1'b0;
    m_drops = 0; m_done = 1; m_trig = 0;
    repeat (3) tick();
    chk("rst_state", state_o, IDLE);
    chk("rst_valid", rd_if.rd_valid, 0);
    chk("rst_last", rd_if.rd_last, 0);
    chk("rst_data", rd_if.rd_data, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b1;
    tick();

    // ch0 every cycle, trigger on the 5th event, three post entries
    do_arm(3);
    for (int i = 0; i < 10; i++) cap_cycle(4'h1, i == 4);
    cap_cycle(4'h1, 1);
    do_dump(0);

    // all channels every cycle: grant order and drop counting
    do_arm(8);
    for (int i = 0; i < 8; i++) cap_cycle(4'hF, i == 0);
    chk("drop_after_all_ch", drop_cnt, 24);
    do_dump(0);

    // 100 pre-trigger writes wrap the buffer; post window of 4
    do_arm(4);
    for (int i = 0; i < 100; i++) cap_cycle(4'($urandom_range(1, 15)), 0);
    for (int i = 0; i < 4; i++) cap_cycle(4'($urandom_range(1, 15)), i == 0);
    do_dump(2);

    // oversize post count clamps; trigger lands on an idle cycle; stalled readout
    do_arm(127);
    for (int i = 0; i < 30; i++) cap_cycle(4'($urandom_range(0, 15)), 0);
    cap_cycle(4'h0, 1);
    for (int i = 0; i < 400 && !m_done; i++) cap_cycle(4'($urandom_range(0, 15)), 0);
    do_dump(1);

    // zero post window, empty dump, dump_start ignored in IDLE
    do_arm(0);
    cap_cycle(4'h0, 1);
    do_dump(0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("dump_in_idle", state_o, IDLE);
    chk("dump_in_idle_valid", rd_if.rd_valid, 0);

    // drop counter saturation
    do_arm(2);
    for (int i = 0; i < 21900; i++) cap_cycle(4'hF, 0);
    chk("drop_sat", drop_cnt, 16'hFFFF);
    cap_cycle(4'h1, 1);
    cap_cycle(4'h1, 0);

    // reset in the middle of a dump
    rd_if.rd_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_valid", rd_if.rd_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", rd_if.rd_valid, 0);
    chk("async_rst_state", state_o, IDLE);
    chk("async_rst_drop", drop_cnt, 0);
    rd_if.rd_ready = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    m_drops = 0;
    do_arm(3);
    cap_cycle(4'b0110, 1);
    cap_cycle(4'b0010, 0);
    cap_cycle(4'b1000, 0);
    do_dump(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
